// File: rtl/bram_rd_arbiter_pkg.sv
// Shared types and defaults for the two-client BRAM read arbiter.
// The optional BRAM_RD_ARB_DEBUG_EN build adds a debug/status port on the top.
package bram_rd_arb_pkg;

  localparam int ARB_ADDR_W = 13;
  localparam int ARB_DATA_W = 32;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bram_rd_arbiter_if.sv
// Bundle of the two client trig/addr/data/done handshakes plus the BRAM read port.
// slave = arbiter side, master = client/BRAM side.
interface bram_rd_arbiter_if
  import bram_rd_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              i_trig0;
  logic              i_trig1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] o_data0;
  logic [DATA_W-1:0] o_data1;
  logic              o_done0;
  logic              o_done1;
  logic              o_bram_en;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] i_bram_dout;

  modport slave (
    input  i_trig0, i_trig1, i_addr0, i_addr1, i_bram_dout,
    output o_data0, o_data1, o_done0, o_done1, o_bram_en, o_bram_addr
  );

  modport master (
    output i_trig0, i_trig1, i_addr0, i_addr1, i_bram_dout,
    input  o_data0, o_data1, o_done0, o_done1, o_bram_en, o_bram_addr
  );

endinterface

// File: rtl/bram_rd_arbiter_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the client
// that was not granted last. Purely combinational; rr_last lives in the parent.
module rd_arb_rr2
  import bram_rd_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic gnt,
  output logic gnt_vld
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt     = CLIENT0;
    if (req0 && req1) begin
      gnt = ~rr_last;
    end else if (req1) begin
      gnt = CLIENT1;
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shared BRAM read controller: two clients, one fixed-latency read port, one word
// per 4-phase trig/done transaction. Define BRAM_RD_ARB_DEBUG_EN for the o_debug port.
module bram_rd_arbiter
  import bram_rd_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  bram_rd_arbiter_if.slave    bus
`ifdef BRAM_RD_ARB_DEBUG_EN
  ,
  output logic [63:0]         o_debug
`endif
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              done_pre0_q, done_pre0_d;
  logic              done_pre1_q, done_pre1_d;

  logic              pick;
  logic              pick_vld;
  logic              trig_gnt;

  rd_arb_rr2 u_rr2 (
    .req0    (bus.i_trig0),
    .req1    (bus.i_trig1),
    .rr_last (rr_last_q),
    .gnt     (pick),
    .gnt_vld (pick_vld)
  );

  assign trig_gnt = grant_q ? bus.i_trig1 : bus.i_trig0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      grant_q     <= CLIENT0;
      rr_last_q   <= CLIENT1;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      done_pre0_q <= 1'b0;
      done_pre1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      done_pre0_q <= done_pre0_d;
      done_pre1_q <= done_pre1_d;
    end
  end

  // en defaults low so the read enable is a single-cycle pulse after the grant edge
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    done_pre0_d = done_pre0_q;
    done_pre1_d = done_pre1_q;

    case (state_q)
      ST_IDLE: begin
        done_pre0_d = 1'b0;
        done_pre1_d = 1'b0;
        if (pick_vld) begin
          grant_d   = pick;
          addr_d    = pick ? bus.i_addr1 : bus.i_addr0;
          en_d      = 1'b1;
          cnt_d     = LAT_INIT;
          rr_last_d = pick;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counting RD_LAT down to zero lands the capture one edge after dout is valid
        if (cnt_q == 3'd0) begin
          if (grant_q) begin
            data1_d     = bus.i_bram_dout;
            done_pre1_d = 1'b1;
          end else begin
            data0_d     = bus.i_bram_dout;
            done_pre0_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (!trig_gnt) begin
          done_pre0_d = 1'b0;
          done_pre1_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gating with trig keeps done low whenever the client has already let go
  assign bus.o_done0     = done_pre0_q & bus.i_trig0;
  assign bus.o_done1     = done_pre1_q & bus.i_trig1;
  assign bus.o_data0     = data0_q;
  assign bus.o_data1     = data1_q;
  assign bus.o_bram_en   = en_q;
  assign bus.o_bram_addr = addr_q;

`ifdef BRAM_RD_ARB_DEBUG_EN
  logic        cap;
  logic [15:0] rd_cnt0_q;
  logic [15:0] rd_cnt1_q;
  logic [15:0] tie_cnt_q;

  assign cap = (state_q == ST_WAIT) && (cnt_q == 3'd0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_cnt0_q <= '0;
      rd_cnt1_q <= '0;
      tie_cnt_q <= '0;
    end else begin
      if (cap && !grant_q) rd_cnt0_q <= rd_cnt0_q + 16'd1;
      if (cap && grant_q)  rd_cnt1_q <= rd_cnt1_q + 16'd1;
      if ((state_q == ST_IDLE) && bus.i_trig0 && bus.i_trig1) begin
        tie_cnt_q <= tie_cnt_q + 16'd1;
      end
    end
  end

  assign o_debug = {tie_cnt_q, rd_cnt1_q, rd_cnt0_q, 6'd0, rr_last_q, grant_q,
                    6'd0, state_q};
`endif

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter with a behavioural fixed-latency BRAM model.
// Debug-counter checks are compiled in when BRAM_RD_ARB_DEBUG_EN is defined.
module tb_bram_rd_arbiter;
  import bram_rd_arb_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  parameter int  RD_LAT = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef BRAM_RD_ARB_DEBUG_EN
  logic [63:0] debug;
`endif

  bram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
`ifdef BRAM_RD_ARB_DEBUG_EN
    ,
    .o_debug(debug)
`endif
  );

  // BRAM model: registered read on en, then RD_LAT-1 further output stages
  logic [31:0] mem  [0:8191];
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.o_bram_en) pipe[0] <= mem[bus.o_bram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_bram_dout = pipe[RD_LAT-1];

  // Log every enable pulse and count enables that last longer than one cycle
  logic [12:0] en_log [$];
  int          en_runs_bad = 0;
  logic        en_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.o_bram_en) en_log.push_back(bus.o_bram_addr);
    if (bus.o_bram_en && en_prev) en_runs_bad <= en_runs_bad + 1;
    en_prev <= bus.o_bram_en;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input bit c, input logic [12:0] a,
                         output logic [31:0] d, output int lat);
    int n = 0;
    bit seen = 1'b0;
    if (c) begin bus.i_addr1 = a; bus.i_trig1 = 1'b1; end
    else   begin bus.i_addr0 = a; bus.i_trig0 = 1'b1; end
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = c ? bus.o_done1 : bus.o_done0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    d   = c ? bus.o_data1 : bus.o_data0;
    lat = n;
    if (c) bus.i_trig1 = 1'b0; else bus.i_trig0 = 1'b0;
    #1;
    chk("done_low_on_drop", 64'(c ? bus.o_done1 : bus.o_done0), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d0a, d0b, d1a, d1b;
    int          lat, l0a, l0b, l1a, l1b;
    int          done_hits;

    for (int i = 0; i < 8192; i++) mem[i] = {16'hC0DE ^ 16'(i * 7), 3'b101, 13'(i)};
    mem[13'h0123] = 32'hDEADBEEF;
    mem[13'h1FFF] = 32'hCAFEF00D;
    bus.i_trig0 = 1'b0; bus.i_trig1 = 1'b0;
    bus.i_addr0 = '0;   bus.i_addr1 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",    64'(bus.o_bram_en),   64'd0);
    chk("rst_addr",  64'(bus.o_bram_addr), 64'd0);
    chk("rst_data0", 64'(bus.o_data0),     64'd0);
    chk("rst_data1", 64'(bus.o_data1),     64'd0);
    chk("rst_done0", 64'(bus.o_done0),     64'd0);
    chk("rst_done1", 64'(bus.o_done1),     64'd0);
`ifdef BRAM_RD_ARB_DEBUG_EN
    chk("rst_debug", debug, 64'h200);
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single read of 0x0123
    en_log.delete();
    do_read(1'b0, 13'h0123, d, lat);
    chk("single_data",    64'(d),             64'hDEADBEEF);
    chk("single_latency", 64'(lat),           64'(RD_LAT + 2));
    chk("single_en_cnt",  64'(en_log.size()), 64'd1);
    chk("single_en_addr", 64'(en_log[0]),     64'h0123);
    chk("single_data1",   64'(bus.o_data1),   64'd0);

    // Row 5 fetch: 16 words with a one-cycle trig gap
    en_log.delete();
    for (int i = 0; i < 16; i++) begin
      do_read(1'b0, 13'(13'h050 + i), d, lat);
      chk("row_data",    64'(d),   64'(mem[13'h050 + i]));
      chk("row_latency", 64'(lat), 64'(RD_LAT + 2));
    end
    chk("row_en_cnt", 64'(en_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("row_en_addr", 64'(en_log[i]), 64'(13'h050 + i));

    // Abort: client 1 drops trig one cycle after its grant
    en_log.delete();
    done_hits = 0;
    bus.i_addr1 = 13'h0777; bus.i_trig1 = 1'b1;
    @(posedge clk); #1;
    if (bus.o_done1) done_hits++;
    @(posedge clk); #1;
    bus.i_trig1 = 1'b0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(posedge clk); #1;
      if (bus.o_done1) done_hits++;
    end
    chk("abort_no_done", 64'(done_hits),   64'd0);
    chk("abort_idle",    64'(dut.state_q), 64'(ST_IDLE));
    chk("abort_data1",   64'(bus.o_data1), 64'(mem[13'h0777]));
    chk("abort_en_addr", 64'(en_log[0]),   64'h0777);
    do_read(1'b0, 13'h0ABC, d, lat);
    chk("post_abort_data",    64'(d),   64'(mem[13'h0ABC]));
    chk("post_abort_latency", 64'(lat), 64'(RD_LAT + 2));

    // Reset pulsed while the read is in flight
    bus.i_addr0 = 13'h0321; bus.i_trig0 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_en_pre",   64'(bus.o_bram_en),   64'd1);
    chk("midrst_addr_pre", 64'(bus.o_bram_addr), 64'h0321);
    rstn = 1'b0;
    #1;
    chk("midrst_en",    64'(bus.o_bram_en),   64'd0);
    chk("midrst_addr",  64'(bus.o_bram_addr), 64'd0);
    chk("midrst_data0", 64'(bus.o_data0),     64'd0);
    chk("midrst_data1", 64'(bus.o_data1),     64'd0);
    chk("midrst_done0", 64'(bus.o_done0),     64'd0);
    bus.i_trig0 = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_read(1'b1, 13'h1FFF, d, lat);
    chk("last_word_data",    64'(d),           64'hCAFEF00D);
    chk("last_word_latency", 64'(lat),         64'(RD_LAT + 2));
    chk("discarded_data0",   64'(bus.o_data0), 64'd0);

    // Contention: both clients request together, two reads each
    en_log.delete();
    fork
      begin
        do_read(1'b0, 13'h0A00, d0a, l0a);
        do_read(1'b0, 13'h0A02, d0b, l0b);
      end
      begin
        do_read(1'b1, 13'h0A01, d1a, l1a);
        do_read(1'b1, 13'h0A03, d1b, l1b);
      end
    join
    chk("cont_d0a", 64'(d0a), 64'(mem[13'h0A00]));
    chk("cont_d0b", 64'(d0b), 64'(mem[13'h0A02]));
    chk("cont_d1a", 64'(d1a), 64'(mem[13'h0A01]));
    chk("cont_d1b", 64'(d1b), 64'(mem[13'h0A03]));
    chk("cont_en_cnt", 64'(en_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("cont_order", 64'(en_log[i]), 64'(13'h0A00 + i));
    chk("en_single_cycle", 64'(en_runs_bad), 64'd0);

`ifdef BRAM_RD_ARB_DEBUG_EN
    chk("dbg_rd_cnt0", 64'(debug[31:16]), 64'd2);
    chk("dbg_rd_cnt1", 64'(debug[47:32]), 64'd3);
    chk("dbg_tie_cnt", 64'(debug[63:48]), 64'd3);
    chk("dbg_low",     64'(debug[15:0]),  64'h0300);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_rd_arbiter.md
Name: bram_rd_arbiter

Overview:
- Shared BRAM read controller that serves the per-word trig/addr/data/done handshake used by the row readers (e.g. the 512-bit row fetcher, 16 word reads per row).
- Arbitrates two read clients onto one synchronous BRAM read port with fixed read latency.
- Returns one 32-bit word per transaction with a 4-phase handshake.
- Sits between the row readers/filters and the frame BRAM.

Parameters:
- ADDR_W, 13, BRAM word-address width (512 rows x 16 words).
- DATA_W, 32, BRAM data width.
- RD_LAT, 2, BRAM read latency in clocks from the en/addr cycle to valid dout (legal 1..4).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_trig0 / i_trig1  in  1  client request, held high until the matching done.
- i_addr0 / i_addr1  in  ADDR_W  client word address, valid while the trig is high.
- o_data0 / o_data1  out  DATA_W  returned word; registered and held between transactions.
- o_done0 / o_done1  out  1  transaction complete; equals done_pre AND the matching trig.
- o_bram_en  out  1  BRAM read enable, one-cycle pulse.
- o_bram_addr  out  ADDR_W  BRAM read address.
- i_bram_dout  in  DATA_W  BRAM read data.

Behaviour:
- Clocking and reset: one clock i_clk; asynchronous active-low reset i_rstn. While reset is asserted, all state and outputs clear: state=IDLE, o_bram_en=0, o_bram_addr=0, o_data0/1=0, done_pre0/1=0, latency counter=0, rr_last=1 (client 0 wins the first tie).
- State machine: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Clear both done_pre.
  - If any trig is high, grant one client. Single requester wins. With both high, the client not equal to rr_last wins (round-robin).
  - On the grant edge: latch grant, o_bram_addr<=granted addr, o_bram_en<=1, counter<=RD_LAT, rr_last<=grant, go to WAIT.
- WAIT:
  - o_bram_en<=0 on the first WAIT edge, so en is high for exactly one cycle.
  - Counter decrements each edge. When the counter reaches 0, capture i_bram_dout into the granted o_dataN, set done_preN, go to DONE.
  - Capture edge is grant edge + RD_LAT + 1. o_doneN is high in the following cycle: 2+RD_LAT cycles after the trig is sampled.
- DONE:
  - Hold done_preN while the granted trig is high.
  - On the edge where the granted trig is sampled low: clear done_preN, go to IDLE. A new grant is possible on the next edge.
  - Minimum trig-low gap accepted is one cycle.
- Output data: o_dataN changes only at its own capture edge. The non-granted client's data is never touched.
- Done safety: o_doneN is combinational AND with i_trigN, so it is never high while the trig is low.
- Abort: if the granted trig drops during WAIT, the read still completes. Data is captured; DONE sees trig low and returns to IDLE on the next edge. No done pulse is visible.
- Starvation bound: with both clients requesting continuously, grants strictly alternate. A losing request waits at most one transaction (RD_LAT+3 cycles).
- Address changes: the address is sampled only at the grant edge. Address changes during WAIT/DONE are ignored.
- Reset mid-transaction: outputs return to their reset values immediately, and the in-flight BRAM read is discarded.

Optional Feature:
- Macro BRAM_RD_ARB_DEBUG_EN.
- Defined: adds output o_debug [63:0]:
  - [7:0] state
  - [8] grant
  - [9] rr_last
  - [31:16] client0 completed-read count
  - [47:32] client1 completed-read count
  - [63:48] count of cycles with both trigs high in IDLE
  - Counters are 16-bit, wrap at 65535->0, and clear on reset.
- Undefined: port and counters are absent; functional behaviour is identical.

Decomposition:
- Package bram_rd_arb_pkg: state encodings (IDLE=0, WAIT=1, DONE=2), ADDR_W/DATA_W defaults, client index constants.
- One natural sub-module, rd_arb_rr2: a 2-way round-robin picker. Inputs are the two requests and rr_last; outputs are the grant index and a grant-valid flag. Purely combinational; rr_last stays in the parent.

Test Plan:
- Single read, RD_LAT=2, BRAM[0x0123]=0xDEADBEEF: i_trig0=1, i_addr0=0x0123 -> o_bram_en pulses once with addr 0x0123; o_data0=0xDEADBEEF; o_done0 high 4 cycles after trig sampled; o_done0 low in the same cycle trig0 drops.
- Row fetch: client 0 issues 16 reads for row 5 (addr 0x050-0x05F) with a 1-cycle trig gap -> 16 en pulses, ascending addresses, each data word matches BRAM contents, no missed or duplicated done.
- Contention: both trigs rise together for 4 back-to-back transactions -> grant order 0,1,0,1; each o_dataN receives only its own address's word.
- Abort: trig1 dropped one cycle after grant -> o_done1 never asserts; o_data1 updated; arbiter back in IDLE within RD_LAT+2 cycles; a subsequent client 0 request is served normally.
- Reset mid-WAIT: i_rstn pulsed low while the counter is nonzero -> all outputs 0 immediately; after release, a read of 0x1FFF (last word) returns the correct data.
- RD_LAT=1 and RD_LAT=4 builds: done latency equals 2+RD_LAT cycles; with BRAM_RD_ARB_DEBUG_EN defined, per-client counters equal the number of completed reads.
